// File: rtl/counter.sv
// Purpose : free-running modulo-2**WIDTH counter with optional one-hot and max-value decode.
// Latency : state updates one clk edge after clear/count; phase and last follow state combinationally.
// Backpressure: none; the counter advances on every edge where clear is low.
//
// Parameters:
//   WIDTH  counter width in bits, legal range 1..4 (default 2)
// Ports:
//   clk    rising-edge clock, sole clock of the block
//   clear  synchronous active-high reset; forces state to 0 and wins over counting
//   state  registered count value
//   phase  one-hot decode of state (bit n high iff state == n)
//   last   high while state == 2**WIDTH-1
//
// Build option: define COUNTER_DECODE_EN to generate the phase/last decode.
// Without it phase and last are tied low and the decode logic is not built.
// The port list is identical in both builds.

module counter #(
  parameter int WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  output logic [WIDTH-1:0]      state,
  output logic [2**WIDTH-1:0]   phase,
  output logic                  last
);

  // The WIDTH-bit add wraps naturally from max to 0; no carry is kept.
  // No initial value is needed: the first clear edge defines the state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= '0;
    end else begin
      state <= state + 1'b1;
    end
  end

`ifdef COUNTER_DECODE_EN
  // Decodes look only at the registered state, so clear reaches the
  // outputs only through the flop.
  always_comb begin
    phase        = '0;
    phase[state] = 1'b1;
    last         = (state == {WIDTH{1'b1}});
  end
`else
  assign phase = '0;
  assign last  = 1'b0;
`endif

endmodule

// File: tb/tb_counter.sv
// Purpose : directed self-checking bench for counter (WIDTH=2 main instance, WIDTH=3 wrap check).
// Latency : outputs are sampled 1 time unit after each rising clk.
// Backpressure: not applicable.

module tb_counter;

  logic       clk;
  logic       clear;
  logic [1:0] state;
  logic [3:0] phase;
  logic       last;
  logic [2:0] state3;
  logic [7:0] phase3;
  logic       last3;

  int n_tests;
  int n_fail;
  int exp3;
  int last_count;

  counter #(.WIDTH(2)) u_dut (
    .clk   (clk),
    .clear (clear),
    .state (state),
    .phase (phase),
    .last  (last)
  );

  counter #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .clear (clear),
    .state (state3),
    .phase (phase3),
    .last  (last3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_phase2(input int s);
`ifdef COUNTER_DECODE_EN
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic exp_last2(input int s);
`ifdef COUNTER_DECODE_EN
    return (s == 3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_phase3(input int s);
`ifdef COUNTER_DECODE_EN
    logic [7:0] one;
    one = 8'b0000_0001;
    return one << s;
`else
    return 8'b0;
`endif
  endfunction

  function automatic logic exp_last3(input int s);
`ifdef COUNTER_DECODE_EN
    return (s == 7);
`else
    return 1'b0;
`endif
  endfunction

  // Drive clear, take one rising edge, then check both instances.
  task automatic step(input logic c, input int exp_s, input string tag);
    clear = c;
    @(posedge clk);
    #1;
    exp3 = c ? 0 : (exp3 + 1) % 8;
    check({tag, ".state"}, 32'(state), 32'(exp_s));
    check({tag, ".phase"}, 32'(phase), 32'(exp_phase2(exp_s)));
    check({tag, ".last"},  32'(last),  32'(exp_last2(exp_s)));
    check({tag, ".state3"}, 32'(state3), 32'(exp3));
    check({tag, ".phase3"}, 32'(phase3), 32'(exp_phase3(exp3)));
    check({tag, ".last3"},  32'(last3),  32'(exp_last3(exp3)));
    if (last === 1'b1) last_count++;
  endtask

  // Hand-computed WIDTH=2 sequences.
  int seq_run[7]   = '{1, 2, 3, 0, 1, 2, 3};
  int seq_free[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp3       = 0;
    last_count = 0;
    clear      = 1'b1;

    // Single clear edge, then release.
    step(1'b1, 0, "clear_init");

    // Seven counting edges after clear.
    foreach (seq_run[i]) step(1'b0, seq_run[i], $sformatf("run%0d", i));

    // Free-run 8 cycles; last must pulse exactly twice with decode built.
    last_count = 0;
    foreach (seq_free[i]) step(1'b0, seq_free[i], $sformatf("free%0d", i));
`ifdef COUNTER_DECODE_EN
    check("free_last_pulses", 32'(last_count), 32'd2);
`else
    check("free_last_pulses", 32'(last_count), 32'd0);
`endif

    // Advance to state 2 (and WIDTH=3 instance through its 7->0 wrap).
    step(1'b0, 0, "adv0");
    step(1'b0, 1, "adv1");
    step(1'b0, 2, "adv2");

    // Raising clear between edges must not disturb state.
    clear = 1'b1;
    #1;
    check("clear_no_comb_path", 32'(state), 32'd2);

    // Clear at state 2, then resume counting.
    step(1'b1, 0, "mid_clear");
    step(1'b0, 1, "mid_resume");
    step(1'b0, 2, "to_max0");
    step(1'b0, 3, "to_max1");

    // Clear on the edge where state is max, then hold it for 3 edges.
    step(1'b1, 0, "clear_at_max");
    step(1'b1, 0, "hold0");
    step(1'b1, 0, "hold1");
    step(1'b1, 0, "hold2");

    // First increment at the first edge with clear low.
    step(1'b0, 1, "release");
    step(1'b0, 2, "release2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 2, counter width in bits; legal range 1..4.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port: clear  input  1  reset, synchronous and active-high, sampled on rising clk.
REQ-004 Port: state  output  WIDTH  current count value, registered.
REQ-005 Port: phase  output  2**WIDTH  one-hot decode of state; bit n high iff state==n.
REQ-006 Port: last  output  1  high while state equals the maximum value (2**WIDTH-1).

Function
REQ-007 On each rising clk with clear=0, state SHALL become (state+1) modulo 2**WIDTH.
- Default WIDTH: sequence 00->01->10->11->00.
REQ-008 Wrap-around: from 2**WIDTH-1, the next state SHALL be 0, with no stall cycle and no carry-out retained.
REQ-009 State SHALL change only on rising clk; no combinational path from clear to state.
REQ-010 Phase SHALL be a combinational decode of registered state, with exactly one bit high at all times after the first clear.
REQ-011 Last SHALL be a combinational decode of registered state, high for exactly one cycle per 2**WIDTH cycles in free-run.
REQ-012 Clear takes priority over counting.
- Clear high on a clock edge where state=max: next state SHALL be 0, not an increment.
REQ-013 Clear held high for N consecutive edges: state SHALL remain 0 for all of them.
- The first increment SHALL occur at the first edge sampled with clear=0.

Reset
REQ-014 On a rising clk with clear=1, state SHALL load 0.
- Consequently phase=1 (bit0 only) and last=0 (for WIDTH>=1 with max!=0).
REQ-015 Before the first clear edge, outputs are undefined; the block SHALL NOT require an initial value.
REQ-016 Clear asserted mid-sequence, at any state, SHALL return state to 0 on that same edge.

Configuration
REQ-017 Macro COUNTER_DECODE_EN controls the decode outputs.
- Defined: phase and last SHALL be driven per REQ-005, REQ-006, REQ-010 and REQ-011.
- Undefined: phase and last SHALL be driven constant 0, the decode logic SHALL be absent, and state behaviour SHALL be unchanged.
- The port list is identical in both builds.

Verification
REQ-018 Hold clear=1 across one rising clk, then clear=0 -> state=00 one time unit after that edge (phase=0001, last=0).
REQ-019 After clear, apply 7 further rising edges with clear=0 -> state sequence 01,10,11,00,01,10,11.
REQ-020 Free-run 8 cycles -> last high only when state=11 (twice); phase always one-hot and matching state.
REQ-021 Assert clear for one edge while state=10 -> state=00 on that edge; counting resumes 01 on the next.
REQ-022 Assert clear on the edge where state=11 -> state=00, not a wrap-driven increment; then hold clear 3 edges -> state stays 00.
REQ-023 Build without COUNTER_DECODE_EN, repeat REQ-019 -> identical state sequence; phase=0000 and last=0 throughout.
